// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one shared column mixer is applied to columns 0..3
// on successive clocks. enable=0 passes the state through with identical timing.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         enable,
  input  logic [127:0] currentState,
  output logic         busy,
  output logic         done,
  output logic [127:0] newState
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_next;
  logic [1:0]   col;
  logic [127:0] buffer, buffer_upd;
  logic         mode;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e products assembled from the shared x2/x4/x8 chain
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]  = c[31 - 8*i -: 8];
      x2    = xt(s[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign col_out = inv_mix(col_in);
  assign busy    = (state == RUN);

  always_comb begin
    col_in     = '0;
    buffer_upd = buffer;
    unique case (col)
      2'd0: col_in = buffer[127:96];
      2'd1: col_in = buffer[95:64];
      2'd2: col_in = buffer[63:32];
      2'd3: col_in = buffer[31:0];
    endcase
    if (mode) begin
      unique case (col)
        2'd0: buffer_upd[127:96] = col_out;
        2'd1: buffer_upd[95:64]  = col_out;
        2'd2: buffer_upd[63:32]  = col_out;
        2'd3: buffer_upd[31:0]   = col_out;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (col == 2'd3) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      buffer   <= '0;
      mode     <= 1'b0;
      newState <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            buffer <= currentState;
            mode   <= enable;
            col    <= '0;
          end
        end
        RUN: begin
          buffer <= buffer_upd;
          col    <= col + 2'd1;
          if (col == 2'd3) begin
            newState <= buffer_upd;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter: driver pushes expected result and due
// cycle per accepted start; a negedge monitor pops and checks on every done.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         enable;
  logic [127:0] currentState;
  logic         busy;
  logic         done;
  logic [127:0] newState;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  inv_mix_columns_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .enable       (enable),
    .currentState (currentState),
    .busy         (busy),
    .done         (done),
    .newState     (newState)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Forward MixColumns, used to build round-trip stimulus
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] r;
    logic [7:0] s0, s1, s2, s3;
    for (int c = 0; c < 4; c++) begin
      s0 = x[127 - 32*c -: 8];
      s1 = x[119 - 32*c -: 8];
      s2 = x[111 - 32*c -: 8];
      s3 = x[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
      r[119 - 32*c -: 8] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
      r[111 - 32*c -: 8] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
      r[103 - 32*c -: 8] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
    end
    return r;
  endfunction

  // Monitor: result value, latency, single-cycle done, and hold between dones
  logic [127:0] prev_ns = '0;
  logic         prev_done = 1'b0;
  exp_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ns   = newState;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (prev_done) chk("done_single_cycle", 128'(prev_done), 128'(0));
        if (sbq.size() == 0) begin
          chk("done_spurious", 128'(done), 128'(0));
        end else begin
          e = sbq.pop_front();
          chk("result", newState, e.data);
          chk("latency_cycle", 128'(cyc), 128'(e.due));
        end
      end else begin
        chk("hold_between_done", newState, prev_ns);
      end
      prev_ns   = newState;
      prev_done = done;
    end
  end

  task automatic issue(input logic [127:0] st, input logic en, input logic [127:0] exp);
    exp_t n;
    @(negedge clk);
    currentState = st;
    enable       = en;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    currentState = ~st;
    enable = ~en;
    n.data = exp;
    n.due  = cyc + 4;
    sbq.push_back(n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("wait_timeout", 128'(sbq.size()), 128'(0));
      sbq.delete();
    end
  endtask

  initial begin
    logic [127:0] x;
    exp_t n;
    rst_n = 1'b0;
    start = 1'b0;
    enable = 1'b0;
    currentState = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_newstate", newState, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round vector and invariant columns
    issue(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1,
          128'hdb135345_f20a225c_01010101_d4d4d4d5);
    wait_idle();
    issue(128'hc6c6c6c6_c6c6c6c6_01010101_4d7ebdf8, 1'b1,
          128'hc6c6c6c6_c6c6c6c6_01010101_2d26314c);
    wait_idle();

    // Bypass
    issue(128'h01234567_89abcdef_fedcba98_76543210, 1'b0,
          128'h01234567_89abcdef_fedcba98_76543210);
    wait_idle();

    // Reset in the middle of a run (at E2): immediate clear, no done afterwards
    issue(128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b0, 128'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 128'(busy), 128'(0));
    chk("midrun_reset_done", 128'(done), 128'(0));
    chk("midrun_reset_newstate", newState, 128'h0);
    sbq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1,
          128'hdb135345_f20a225c_01010101_d4d4d4d5);
    wait_idle();

    // start held high with new data every cycle: accepts every 5th edge only
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      x = {$urandom, $urandom, $urandom, $urandom};
      currentState = mix_columns(x);
      enable = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      if (k % 5 == 0) begin
        n.data = x;
        n.due  = cyc + 4;
        sbq.push_back(n);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Round trip through the forward transform
    for (int k = 0; k < 1000; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      issue(mix_columns(x), 1'b1, x);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("final_busy", 128'(busy), 128'(0));
    chk("final_queue_empty", 128'(sbq.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/inv_mix_columns_iter.md
# inv_mix_columns_iter

Iterative InvMixColumns unit for the AES decryption datapath. It is the inverse counterpart of the combinational MixColumns stage. It accepts a 128-bit state array and applies the inverse column-mixing matrix one column per clock. It then presents the full result with a one-cycle done pulse. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decryption round, and trades three extra cycles for one quarter of the GF(2^8) multiplier area.

## Interface
Parameters:
- none (fixed 128-bit state, 4 columns of 32 bits)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- enable  input  1  sampled with start; 1 = apply InvMixColumns, 0 = pass state through unchanged (last decryption round)
- currentState  input  128  state array; column i = bits [127-32i -: 32], row 0 = most significant byte of the column
- busy  output  1  high while a transform is in progress
- done  output  1  one-cycle pulse when newState is updated
- newState  output  128  result register; holds its value until the next done

## Operation
- States: IDLE, RUN.
- IDLE:
  - On start=1, capture currentState into the working buffer and capture enable into the mode bit.
  - Clear the column counter col to 0, set busy=1, go to RUN.
- RUN, each cycle:
  - If mode=1, replace buffer column col with InvMix(column col). If mode=0, leave the buffer unchanged.
  - col increments.
  - When col=3 is processed: write the updated buffer to newState, pulse done=1, set busy=0, col wraps to 0, return to IDLE.
- InvMix of column (s0,s1,s2,s3) in GF(2^8), reduction polynomial 0x11B:
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Multiplication is built from xtime chains (x2, x4, x8). All intermediates are 8 bits. No carries escape the byte.
- Only one column-mixing unit is instantiated. It is shared across the 4 columns via a mux on col.
- start while busy=1 is ignored: no capture, no queuing. Changes to currentState and enable after acceptance have no effect.

## Timing
- Reset values: busy=0, done=0, newState=128'h0, col=0, state=IDLE, buffer=0, mode=0.
- Acceptance: start=1 with busy=0 at rising edge E0. busy is high after E0.
- Columns 0,1,2,3 are processed at edges E1,E2,E3,E4.
- At E4: newState updated, done=1 for the cycle after E4, busy=0.
- Latency from the accepting edge to newState valid is 4 clocks. Maximum throughput is one block per 5 clocks.
- start high at E4 is sampled while busy=1, so it is ignored. The earliest next acceptance is E5.
- Bypass (enable=0) has the identical 4-clock latency and identical done timing.
- done never asserts without a prior accepted start. It is never high for two consecutive cycles.
- rst_n low at any time, including mid-RUN:
  - All registers return to reset values immediately.
  - The in-flight transform is discarded and no done is produced.
  - Operation resumes on the first edge after rst_n rises.

## Test plan
- Reset: assert rst_n=0 mid-run (at E2) → busy=0, done=0, and newState=0 immediately. No done follows. A subsequent start is accepted normally.
- FIPS-197 vectors, enable=1: currentState=8e4da1bc_9fdc589d_01010101_d5d5d7d6 → after 4 clocks newState=db135345_f20a225c_01010101_d4d4d4d5, with a single done pulse.
- Invariant column, enable=1: currentState=c6c6c6c6_c6c6c6c6_01010101_2d26314c → wait, use currentState=c6c6c6c6_c6c6c6c6_01010101_4d7ebdf8 → newState=c6c6c6c6_c6c6c6c6_01010101_2d26314c.
- Bypass: enable=0, currentState=0123456789abcdef_fedcba9876543210 → newState equals the input exactly, and done appears 4 clocks after acceptance.
- Busy handling: hold start=1 continuously with changing currentState → accepts occur at E0, E5, E10, …. Each result matches the input sampled at its own accepting edge. Inputs presented during busy have no effect.
- Round trip: random 128-bit X → MixColumns → this block (enable=1) returns X for 1000 random vectors. newState stays stable between done pulses.
